// File: rtl/psum_collector_if.sv
// psum_collector_if: bundles the bottom-row psum write bus and the drain
// control/stream of psum_collector.
//   Write bus : i_Psum_In, i_Addr_P_In, i_Valid_P_In, i_Acc_Mode
//   Drain ctl : i_Drain_Start, i_Drain_Len, i_Clear_On_Drain
//   Stream    : o_Drain_Data, o_Drain_Addr, o_Drain_Valid, i_Drain_Ready
//   Status    : o_Drain_Done, o_Busy
// slave = collector side, master = array/writeback side.
interface psum_collector_if #(
  parameter int PE_COL    = 8,
  parameter int BIT_PSUM  = 32,
  parameter int BIT_ADDR  = 4,
  parameter int BIT_VALID = 1
);
  logic [PE_COL*BIT_PSUM-1:0]  i_Psum_In;
  logic [PE_COL*BIT_ADDR-1:0]  i_Addr_P_In;
  logic [PE_COL*BIT_VALID-1:0] i_Valid_P_In;
  logic                        i_Acc_Mode;
  logic                        i_Drain_Start;
  logic [BIT_ADDR:0]           i_Drain_Len;
  logic                        i_Clear_On_Drain;
  logic [PE_COL*BIT_PSUM-1:0]  o_Drain_Data;
  logic [BIT_ADDR-1:0]         o_Drain_Addr;
  logic                        o_Drain_Valid;
  logic                        i_Drain_Ready;
  logic                        o_Drain_Done;
  logic                        o_Busy;

  modport slave (
    input  i_Psum_In, i_Addr_P_In, i_Valid_P_In, i_Acc_Mode,
    input  i_Drain_Start, i_Drain_Len, i_Clear_On_Drain, i_Drain_Ready,
    output o_Drain_Data, o_Drain_Addr, o_Drain_Valid, o_Drain_Done, o_Busy
  );

  modport master (
    output i_Psum_In, i_Addr_P_In, i_Valid_P_In, i_Acc_Mode,
    output i_Drain_Start, i_Drain_Len, i_Clear_On_Drain, i_Drain_Ready,
    input  o_Drain_Data, o_Drain_Addr, o_Drain_Valid, o_Drain_Done, o_Busy
  );
endinterface

// File: rtl/psum_collector.sv
// psum_collector: captures per-column partial sums from the bottom PE row
// into PE_COL independent register banks (accumulate or overwrite), and on
// request drains the banks row by row over a valid/ready stream.
// Ports:
//   CLK, RSTn : clock, async active-low reset (clears all state and buffer)
//   io        : psum_collector_if.slave (write bus, drain control, stream)

// One column bank: DEPTH x BIT_PSUM registers, combinational read port,
// one read-modify-write port and a row-clear port.
module psum_col_bank #(
  parameter int BIT_PSUM = 32,
  parameter int BIT_ADDR = 4
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                i_wr_vld,
  input  logic                i_acc,
  input  logic [BIT_ADDR-1:0] i_wr_addr,
  input  logic [BIT_PSUM-1:0] i_psum,
  input  logic                i_clr,
  input  logic [BIT_ADDR-1:0] i_clr_addr,
  input  logic [BIT_ADDR-1:0] i_rd_addr,
  output logic [BIT_PSUM-1:0] o_rd_data
);
  localparam int DEPTH = 1 << BIT_ADDR;

  logic [BIT_PSUM-1:0] r_mem [DEPTH];
  logic                w_clr_hit;

  // A write colliding with a clear of the same row sees the entry as 0.
  assign w_clr_hit = i_clr && (i_clr_addr == i_wr_addr);
  assign o_rd_data = r_mem[i_rd_addr];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int e = 0; e < DEPTH; e++) r_mem[e] <= '0;
    end else begin
      if (i_clr) r_mem[i_clr_addr] <= '0;
      // Later NBA overrides the clear when both hit the same row.
      if (i_wr_vld)
        r_mem[i_wr_addr] <= (i_acc && !w_clr_hit) ? r_mem[i_wr_addr] + i_psum : i_psum;
    end
  end
endmodule

module psum_collector #(
  parameter int PE_COL    = 8,
  parameter int BIT_PSUM  = 32,
  parameter int BIT_ADDR  = 4,
  parameter int BIT_VALID = 1
) (
  input  logic             CLK,
  input  logic             RSTn,
  psum_collector_if.slave  io
);
  localparam logic [BIT_ADDR-1:0] IDX_ONE = 1;
  localparam logic [BIT_ADDR:0]   LEN_ONE = 1;

  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t                             r_state, w_state_n;
  logic [BIT_ADDR-1:0]                r_idx, w_idx_n;
  logic [BIT_ADDR:0]                  r_len;
  logic                               r_clr;
  logic                               r_valid, w_valid_n;
  logic                               r_done, w_done_n;
  logic [PE_COL-1:0][BIT_PSUM-1:0]    r_data;

  logic                               w_load, w_latch, w_clr, w_last;
  logic [BIT_ADDR-1:0]                w_rd_addr;
  logic [PE_COL-1:0][BIT_PSUM-1:0]    w_psum, w_rd;
  logic [PE_COL-1:0][BIT_ADDR-1:0]    w_addr;
  logic [PE_COL-1:0]                  w_vld;

  assign w_psum = io.i_Psum_In;
  assign w_addr = io.i_Addr_P_In;
  assign w_last = ({1'b0, r_idx} == (r_len - LEN_ONE));

  genvar c;
  generate
    for (c = 0; c < PE_COL; c++) begin : g_col
      assign w_vld[c] = io.i_Valid_P_In[BIT_VALID*c];
      psum_col_bank #(.BIT_PSUM(BIT_PSUM), .BIT_ADDR(BIT_ADDR)) u_bank (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .i_wr_vld   (w_vld[c]),
        .i_acc      (io.i_Acc_Mode),
        .i_wr_addr  (w_addr[c]),
        .i_psum     (w_psum[c]),
        .i_clr      (w_clr),
        .i_clr_addr (r_idx),
        .i_rd_addr  (w_rd_addr),
        .o_rd_data  (w_rd[c])
      );
    end
  endgenerate

  // In DRAIN the output is always valid, so a handshake is just ready.
  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_valid_n = r_valid;
    w_done_n  = 1'b0;
    w_load    = 1'b0;
    w_latch   = 1'b0;
    w_clr     = 1'b0;
    w_rd_addr = r_idx + IDX_ONE;
    case (r_state)
      S_IDLE: begin
        if (io.i_Drain_Start) begin
          if (io.i_Drain_Len == '0) begin
            w_done_n = 1'b1;
          end else begin
            w_state_n = S_DRAIN;
            w_idx_n   = '0;
            w_rd_addr = '0;
            w_load    = 1'b1;
            w_valid_n = 1'b1;
            w_latch   = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (io.i_Drain_Ready) begin
          w_clr = r_clr;
          if (w_last) begin
            w_state_n = S_IDLE;
            w_valid_n = 1'b0;
            w_done_n  = 1'b1;
          end else begin
            w_idx_n = r_idx + IDX_ONE;
            w_load  = 1'b1;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_clr   <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_n;
      r_idx   <= w_idx_n;
      r_valid <= w_valid_n;
      r_done  <= w_done_n;
      if (w_latch) begin
        r_len <= io.i_Drain_Len;
        r_clr <= io.i_Clear_On_Drain;
      end
      // Snapshot of pre-edge memory; same-edge writes are not visible.
      if (w_load) r_data <= w_rd;
    end
  end

  assign io.o_Drain_Data  = r_data;
  assign io.o_Drain_Addr  = r_idx;
  assign io.o_Drain_Valid = r_valid;
  assign io.o_Drain_Done  = r_done;
  assign io.o_Busy        = (r_state == S_DRAIN);
endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector: directed, table-driven bench for psum_collector.
module tb_psum_collector;
  localparam int PE_COL = 8;
  localparam int BP     = 32;
  localparam int BA     = 4;
  localparam int DEPTH  = 16;

  typedef logic [PE_COL-1:0][BP-1:0] row_t;
  typedef struct {
    int          col;
    logic [3:0]  addr;
    logic [31:0] psum;
    logic        acc;
    logic [31:0] exp;
    bit          last;
  } vec_t;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  psum_collector_if #(.PE_COL(PE_COL), .BIT_PSUM(BP), .BIT_ADDR(BA), .BIT_VALID(1)) bus();

  psum_collector #(.PE_COL(PE_COL), .BIT_PSUM(BP), .BIT_ADDR(BA), .BIT_VALID(1)) dut (
    .CLK  (clk),
    .RSTn (rstn),
    .io   (bus)
  );

  int   nerr = 0;
  int   nchk = 0;
  row_t got     [DEPTH];
  row_t exp_img [DEPTH];
  vec_t tbl     [9];

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input int c, input logic [3:0] a, input logic [31:0] v, input logic acc);
    bus.i_Valid_P_In[c]        = 1'b1;
    bus.i_Addr_P_In[4*c +: 4]  = a;
    bus.i_Psum_In[32*c +: 32]  = v;
    bus.i_Acc_Mode             = acc;
  endtask

  task automatic wr_off();
    bus.i_Valid_P_In = '0;
  endtask

  task automatic clr_img();
    for (int r = 0; r < DEPTH; r++) exp_img[r] = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, " data"},  bus.o_Drain_Data,  '0);
    chk({tag, " addr"},  bus.o_Drain_Addr,  '0);
    chk({tag, " valid"}, bus.o_Drain_Valid, '0);
    chk({tag, " done"},  bus.o_Drain_Done,  '0);
    chk({tag, " busy"},  bus.o_Busy,        '0);
  endtask

  // Full-rate drain; captures rows into got[] and checks stream framing.
  task automatic drain(input int len, input bit clr, input string tag);
    bus.i_Drain_Start    = 1'b1;
    bus.i_Drain_Len      = 5'(len);
    bus.i_Clear_On_Drain = clr;
    bus.i_Drain_Ready    = 1'b1;
    tick();
    bus.i_Drain_Start = 1'b0;
    for (int k = 0; k < len; k++) begin
      chk($sformatf("%s valid r%0d", tag, k), bus.o_Drain_Valid, 1);
      chk($sformatf("%s busy r%0d", tag, k),  bus.o_Busy, 1);
      chk($sformatf("%s addr r%0d", tag, k),  bus.o_Drain_Addr, k);
      got[k] = bus.o_Drain_Data;
      tick();
    end
    chk({tag, " done pulse"},  bus.o_Drain_Done,  1);
    chk({tag, " valid after"}, bus.o_Drain_Valid, 0);
    chk({tag, " busy after"},  bus.o_Busy,        0);
    tick();
    chk({tag, " done cleared"}, bus.o_Drain_Done, 0);
  endtask

  initial begin
    row_t er;
    tbl[0] = '{0, 4'd3,  32'd5,          1'b1, 32'd5,          1'b0};
    tbl[1] = '{0, 4'd3,  32'd7,          1'b1, 32'd12,         1'b0};
    tbl[2] = '{0, 4'd3,  32'hFFFF_FFFE,  1'b1, 32'd10,         1'b1};
    tbl[3] = '{1, 4'd0,  32'hFFFF_FFFF,  1'b0, 32'hFFFF_FFFF,  1'b0};
    tbl[4] = '{2, 4'd0,  32'd9,          1'b0, 32'd9,          1'b1};
    tbl[5] = '{1, 4'd0,  32'd1,          1'b1, 32'd0,          1'b1};
    tbl[6] = '{3, 4'd15, 32'h1234_5678,  1'b0, 32'h1234_5678,  1'b0};
    tbl[7] = '{3, 4'd15, 32'h8000_0000,  1'b1, 32'h9234_5678,  1'b1};
    tbl[8] = '{7, 4'd15, 32'hDEAD_BEEF,  1'b1, 32'hDEAD_BEEF,  1'b1};

    bus.i_Psum_In = '0; bus.i_Addr_P_In = '0; bus.i_Valid_P_In = '0;
    bus.i_Acc_Mode = 1'b0; bus.i_Drain_Start = 1'b0; bus.i_Drain_Len = '0;
    bus.i_Clear_On_Drain = 1'b0; bus.i_Drain_Ready = 1'b0;

    #2 rstn = 1'b0;
    tick(); tick();
    chk_outs_zero("reset");
    rstn = 1'b1;
    tick();

    // Table: accumulate, overwrite, wrap, column independence.
    clr_img();
    for (int i = 0; i < 9; i++) begin
      wr_off();
      wr(tbl[i].col, tbl[i].addr, tbl[i].psum, tbl[i].acc);
      if (tbl[i].last) exp_img[tbl[i].addr][tbl[i].col] = tbl[i].exp;
      tick();
    end
    wr_off();
    tick();
    drain(DEPTH, 1'b0, "full");
    for (int r = 0; r < DEPTH; r++) chk($sformatf("full row%0d", r), got[r], exp_img[r]);

    // len=0: done pulse only.
    bus.i_Drain_Start = 1'b1; bus.i_Drain_Len = '0;
    tick();
    bus.i_Drain_Start = 1'b0;
    chk("len0 done",  bus.o_Drain_Done,  1);
    chk("len0 valid", bus.o_Drain_Valid, 0);
    chk("len0 busy",  bus.o_Busy,        0);
    tick();
    chk("len0 done off", bus.o_Drain_Done, 0);

    // Backpressure, plus a start issued mid-drain.
    do_reset();
    clr_img();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < PE_COL; c++) begin
        wr(c, 4'(r), 32'hA000_0000 + 32'(r * 256 + c), 1'b0);
        exp_img[r][c] = 32'hA000_0000 + 32'(r * 256 + c);
      end
      tick();
    end
    wr_off();
    bus.i_Drain_Start = 1'b1; bus.i_Drain_Len = 5'd3; bus.i_Clear_On_Drain = 1'b0;
    bus.i_Drain_Ready = 1'b0;
    tick();
    bus.i_Drain_Start = 1'b0;
    chk("bp row0 data", bus.o_Drain_Data, exp_img[0]);
    chk("bp row0 addr", bus.o_Drain_Addr, 0);
    bus.i_Drain_Ready = 1'b1;
    tick();
    chk("bp row1 data", bus.o_Drain_Data, exp_img[1]);
    chk("bp row1 addr", bus.o_Drain_Addr, 1);
    bus.i_Drain_Ready = 1'b0;
    bus.i_Drain_Start = 1'b1; bus.i_Drain_Len = '0;
    tick();
    bus.i_Drain_Start = 1'b0;
    chk("bp stall1 data",  bus.o_Drain_Data,  exp_img[1]);
    chk("bp stall1 valid", bus.o_Drain_Valid, 1);
    tick();
    chk("bp stall2 data", bus.o_Drain_Data, exp_img[1]);
    chk("bp stall2 addr", bus.o_Drain_Addr, 1);
    chk("bp ignore start done", bus.o_Drain_Done, 0);
    bus.i_Drain_Ready = 1'b1;
    tick();
    chk("bp row2 data", bus.o_Drain_Data, exp_img[2]);
    chk("bp row2 addr", bus.o_Drain_Addr, 2);
    chk("bp row2 done", bus.o_Drain_Done, 0);
    tick();
    chk("bp done",  bus.o_Drain_Done,  1);
    chk("bp valid", bus.o_Drain_Valid, 0);
    chk("bp busy",  bus.o_Busy,        0);
    tick();
    chk("bp done off", bus.o_Drain_Done, 0);

    // Clear-on-drain with a same-edge accumulate.
    do_reset();
    wr(0, 4'd2, 32'd4, 1'b0);
    wr(5, 4'd1, 32'd77, 1'b0);
    tick();
    wr_off();
    bus.i_Drain_Start = 1'b1; bus.i_Drain_Len = 5'd4; bus.i_Clear_On_Drain = 1'b1;
    bus.i_Drain_Ready = 1'b1;
    tick();
    bus.i_Drain_Start = 1'b0;
    chk("clr row0 addr", bus.o_Drain_Addr, 0);
    tick();
    er = '0; er[5] = 32'd77;
    chk("clr row1 data", bus.o_Drain_Data, er);
    tick();
    er = '0; er[0] = 32'd4;
    chk("clr row2 data", bus.o_Drain_Data, er);
    wr(0, 4'd2, 32'd6, 1'b1);
    tick();
    wr_off();
    chk("clr row3 addr", bus.o_Drain_Addr, 3);
    chk("clr row3 data", bus.o_Drain_Data, '0);
    tick();
    chk("clr done", bus.o_Drain_Done, 1);
    tick();
    clr_img();
    exp_img[2][0] = 32'd6;
    drain(4, 1'b0, "post clr");
    for (int r = 0; r < 4; r++) chk($sformatf("post clr row%0d", r), got[r], exp_img[r]);

    // Async reset mid-drain.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < PE_COL; c++) wr(c, 4'(r), 32'h5500 + 32'(r * 16 + c), 1'b0);
      tick();
    end
    wr_off();
    bus.i_Drain_Start = 1'b1; bus.i_Drain_Len = 5'd4; bus.i_Clear_On_Drain = 1'b0;
    bus.i_Drain_Ready = 1'b1;
    tick();
    bus.i_Drain_Start = 1'b0;
    tick();
    chk("rst mid addr1", bus.o_Drain_Addr, 1);
    #2 rstn = 1'b0;
    #1 chk_outs_zero("rst mid");
    tick();
    rstn = 1'b1;
    tick();
    drain(4, 1'b0, "after rst");
    for (int r = 0; r < 4; r++) chk($sformatf("after rst row%0d", r), got[r], '0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
